// File: rtl/apb2axi_pkg.sv
// Shared types and AXI encodings for the APB-to-AXI bridge.
package apb2axi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrReq,
        StWrResp,
        StRdReq,
        StRdResp,
        StDone
    } state_e;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_4B     = 3'b010;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/apb2axi_bridge.sv
// APB3 slave to AXI3 master bridge: each APB transfer becomes one single-beat AXI
// transaction, with PREADY held off until the AXI response has been taken.
module apb2axi_bridge
    import apb2axi_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned AXI_ID     = 0
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    psel_i,
    input  logic                    penable_i,
    input  logic                    pwrite_i,
    input  logic [ADDR_WIDTH-1:0]   paddr_i,
    input  logic [DATA_WIDTH-1:0]   pwdata_i,
    output logic [DATA_WIDTH-1:0]   prdata_o,
    output logic                    pready_o,
    output logic                    pslverr_o,

    output logic [ID_WIDTH-1:0]     awid_o,
    output logic [ADDR_WIDTH-1:0]   awaddr_o,
    output logic [3:0]              awlen_o,
    output logic [2:0]              awsize_o,
    output logic [1:0]              awburst_o,
    output logic                    awvalid_o,
    input  logic                    awready_i,

    output logic [ID_WIDTH-1:0]     wid_o,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic [DATA_WIDTH/8-1:0] wstrb_o,
    output logic                    wlast_o,
    output logic                    wvalid_o,
    input  logic                    wready_i,

    input  logic [ID_WIDTH-1:0]     bid_i,
    input  logic [1:0]              bresp_i,
    input  logic                    bvalid_i,
    output logic                    bready_o,

    output logic [ID_WIDTH-1:0]     arid_o,
    output logic [ADDR_WIDTH-1:0]   araddr_o,
    output logic [3:0]              arlen_o,
    output logic [2:0]              arsize_o,
    output logic [1:0]              arburst_o,
    output logic                    arvalid_o,
    input  logic                    arready_i,

    input  logic [ID_WIDTH-1:0]     rid_i,
    input  logic [DATA_WIDTH-1:0]   rdata_i,
    input  logic [1:0]              rresp_i,
    input  logic                    rlast_i,
    input  logic                    rvalid_i,
    output logic                    rready_o
);

    localparam logic [ID_WIDTH-1:0] AxiIdVal = ID_WIDTH'(AXI_ID);

    state_e                  state_q, state_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    arvalid_q, arvalid_d;
    logic                    bready_q, bready_d;
    logic                    rready_q, rready_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

    // Byte offset is dropped: every transfer is a full aligned word.
    logic unused_paddr;
    assign unused_paddr = ^paddr_i[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    // Next-state logic computes the next value of every registered output, so all
    // outputs come straight from flops.
    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        bready_d  = bready_q;
        rready_d  = rready_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;

        unique case (state_q)
            StIdle: begin
                if (psel_i && !penable_i) begin
                    addr_d  = {paddr_i[ADDR_WIDTH-1:2], 2'b00};
                    wdata_d = pwdata_i;
                    if (pwrite_i) begin
                        state_d   = StWrReq;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = StRdReq;
                        arvalid_d = 1'b1;
                    end
                end
            end
            StWrReq: begin
                if (awready_i) awvalid_d = 1'b0;
                if (wready_i)  wvalid_d  = 1'b0;
                if ((!awvalid_q || awready_i) && (!wvalid_q || wready_i)) begin
                    state_d  = StWrResp;
                    bready_d = 1'b1;
                end
            end
            StWrResp: begin
                if (bvalid_i) begin
                    state_d   = StDone;
                    bready_d  = 1'b0;
                    pready_d  = 1'b1;
                    prdata_d  = '0;
                    pslverr_d = (bresp_i != RESP_OKAY) || (bid_i != AxiIdVal);
                end
            end
            StRdReq: begin
                if (arready_i) begin
                    state_d   = StRdResp;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            StRdResp: begin
                if (rvalid_i) begin
                    state_d   = StDone;
                    rready_d  = 1'b0;
                    pready_d  = 1'b1;
                    prdata_d  = rdata_i;
                    pslverr_d = (rresp_i != RESP_OKAY) || (rid_i != AxiIdVal) || !rlast_i;
                end
            end
            StDone: begin
                state_d   = StIdle;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    assign prdata_o  = prdata_q;
    assign pready_o  = pready_q;
    assign pslverr_o = pslverr_q;

    assign awid_o    = AxiIdVal;
    assign awaddr_o  = addr_q;
    assign awlen_o   = 4'd0;
    assign awsize_o  = SIZE_4B;
    assign awburst_o = BURST_INCR;
    assign awvalid_o = awvalid_q;

    assign wid_o     = AxiIdVal;
    assign wdata_o   = wdata_q;
    assign wstrb_o   = '1;
    assign wlast_o   = 1'b1;
    assign wvalid_o  = wvalid_q;

    assign bready_o  = bready_q;

    assign arid_o    = AxiIdVal;
    assign araddr_o  = addr_q;
    assign arlen_o   = 4'd0;
    assign arsize_o  = SIZE_4B;
    assign arburst_o = BURST_INCR;
    assign arvalid_o = arvalid_q;

    assign rready_o  = rready_q;

endmodule

// File: tb/tb_apb2axi_bridge.sv
// Bench for apb2axi_bridge: APB driver, delay-configurable AXI slave, scoreboard of
// expected APB completions and expected AXI requests from a word-memory reference model.
module tb_apb2axi_bridge;

    localparam logic [3:0] TB_ID = 4'h5;

    logic        clk;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata_o;
    logic        pready_o, pslverr_o;
    logic [3:0]  awid_o, awlen_o, wid_o, arid_o, arlen_o;
    logic [31:0] awaddr_o, araddr_o, wdata_o;
    logic [2:0]  awsize_o, arsize_o;
    logic [1:0]  awburst_o, arburst_o;
    logic [3:0]  wstrb_o;
    logic        awvalid_o, wvalid_o, wlast_o, arvalid_o, bready_o, rready_o;
    logic        awready, wready, arready;
    logic [3:0]  bid, rid;
    logic [1:0]  bresp, rresp;
    logic        bvalid, rvalid, rlast;
    logic [31:0] rdata;

    apb2axi_bridge #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .ID_WIDTH  (4),
        .AXI_ID    (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .psel_i    (psel),
        .penable_i (penable),
        .pwrite_i  (pwrite),
        .paddr_i   (paddr),
        .pwdata_i  (pwdata),
        .prdata_o  (prdata_o),
        .pready_o  (pready_o),
        .pslverr_o (pslverr_o),
        .awid_o    (awid_o),
        .awaddr_o  (awaddr_o),
        .awlen_o   (awlen_o),
        .awsize_o  (awsize_o),
        .awburst_o (awburst_o),
        .awvalid_o (awvalid_o),
        .awready_i (awready),
        .wid_o     (wid_o),
        .wdata_o   (wdata_o),
        .wstrb_o   (wstrb_o),
        .wlast_o   (wlast_o),
        .wvalid_o  (wvalid_o),
        .wready_i  (wready),
        .bid_i     (bid),
        .bresp_i   (bresp),
        .bvalid_i  (bvalid),
        .bready_o  (bready_o),
        .arid_o    (arid_o),
        .araddr_o  (araddr_o),
        .arlen_o   (arlen_o),
        .arsize_o  (arsize_o),
        .arburst_o (arburst_o),
        .arvalid_o (arvalid_o),
        .arready_i (arready),
        .rid_i     (rid),
        .rdata_i   (rdata),
        .rresp_i   (rresp),
        .rlast_i   (rlast),
        .rvalid_i  (rvalid),
        .rready_o  (rready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave behaviour knobs
    int unsigned aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [3:0]  cfg_bid = TB_ID, cfg_rid = TB_ID;
    logic        cfg_rlast = 1'b1;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_data = '0;

    // Expectations
    typedef struct {
        logic [31:0] data;
        logic        err;
        int unsigned t0;
        int unsigned lat;
    } apb_exp_t;
    apb_exp_t    sb_q[$];
    logic [31:0] exp_aw[$];
    logic [31:0] exp_w[$];
    logic [31:0] exp_ar[$];
    logic [31:0] m_mem[logic [31:0]];
    logic [31:0] s_mem[logic [31:0]];

    function automatic logic [31:0] def_word(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    // APB completion monitor
    always @(negedge clk) begin : mon
        apb_exp_t e;
        if (!rst && pready_o) begin
            if (sb_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL pready: got unexpected completion, expected none (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                check("prdata", prdata_o, e.data);
                check("pslverr", pslverr_o, e.err);
                if (e.lat != 0) check("latency", cyc - e.t0, e.lat);
            end
        end
    end

    // AXI slave: handshakes seen at a falling edge complete on the next rising edge
    int unsigned aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    int unsigned aw_hi_cnt, w_hi_cnt, b_hs_cnt;
    logic        aw_pend, w_pend, ar_pend, b_pend, r_pend;
    logic        aw_got, w_got, ar_got;
    logic [31:0] s_waddr, s_wdata, s_raddr;

    initial begin
        logic [31:0] x;
        {awready, wready, arready, bvalid, rvalid, rlast} = '0;
        {bid, rid, bresp, rresp, rdata} = '0;
        {aw_pend, w_pend, ar_pend, b_pend, r_pend, aw_got, w_got, ar_got} = '0;
        {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
        {aw_hi_cnt, w_hi_cnt, b_hs_cnt} = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                {awready, wready, arready, bvalid, rvalid} = '0;
                {aw_pend, w_pend, ar_pend, b_pend, r_pend, aw_got, w_got, ar_got} = '0;
                {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
            end else begin
                if (aw_pend) begin awready = 1'b0; aw_pend = 1'b0; aw_got = 1'b1; end
                if (w_pend)  begin wready = 1'b0;  w_pend = 1'b0;  w_got = 1'b1;  end
                if (ar_pend) begin arready = 1'b0; ar_pend = 1'b0; ar_got = 1'b1; end
                if (b_pend)  begin bvalid = 1'b0;  b_pend = 1'b0;  aw_got = 1'b0; w_got = 1'b0; end
                if (r_pend)  begin rvalid = 1'b0;  r_pend = 1'b0;  ar_got = 1'b0; end

                if (aw_got && w_got && !bvalid) begin
                    if (b_cnt >= b_delay) begin
                        bvalid = 1'b1; bresp = cfg_bresp; bid = cfg_bid; b_cnt = 0;
                    end else b_cnt++;
                end
                if (bvalid && bready_o && !b_pend) begin
                    b_pend = 1'b1;
                    b_hs_cnt++;
                    s_mem[s_waddr] = s_wdata;
                end
                if (ar_got && !rvalid) begin
                    if (r_cnt >= r_delay) begin
                        rvalid = 1'b1; rresp = cfg_rresp; rid = cfg_rid; rlast = cfg_rlast;
                        rdata = ovr_en ? ovr_data :
                                (s_mem.exists(s_raddr) ? s_mem[s_raddr] : def_word(s_raddr));
                        r_cnt = 0;
                    end else r_cnt++;
                end
                if (rvalid && rready_o && !r_pend) r_pend = 1'b1;

                if (awvalid_o) aw_hi_cnt++;
                if (wvalid_o)  w_hi_cnt++;
                if (awvalid_o && !awready) begin
                    if (aw_cnt >= aw_delay) begin
                        awready = 1'b1; aw_pend = 1'b1; aw_cnt = 0; s_waddr = awaddr_o;
                        if (exp_aw.size() == 0) check("aw unexpected", 1, 0);
                        else begin
                            x = exp_aw.pop_front();
                            check("awaddr", awaddr_o, x);
                            check("aw fields", {awid_o, awlen_o, awsize_o, awburst_o},
                                  {TB_ID, 4'd0, 3'd2, 2'd1});
                        end
                    end else aw_cnt++;
                end
                if (wvalid_o && !wready) begin
                    if (w_cnt >= w_delay) begin
                        wready = 1'b1; w_pend = 1'b1; w_cnt = 0; s_wdata = wdata_o;
                        if (exp_w.size() == 0) check("w unexpected", 1, 0);
                        else begin
                            x = exp_w.pop_front();
                            check("wdata", wdata_o, x);
                            check("w fields", {wid_o, wstrb_o, wlast_o}, {TB_ID, 4'hF, 1'b1});
                        end
                    end else w_cnt++;
                end
                if (arvalid_o && !arready) begin
                    if (ar_cnt >= ar_delay) begin
                        arready = 1'b1; ar_pend = 1'b1; ar_cnt = 0; s_raddr = araddr_o;
                        if (exp_ar.size() == 0) check("ar unexpected", 1, 0);
                        else begin
                            x = exp_ar.pop_front();
                            check("araddr", araddr_o, x);
                            check("ar fields", {arid_o, arlen_o, arsize_o, arburst_o},
                                  {TB_ID, 4'd0, 3'd2, 2'd1});
                        end
                    end else ar_cnt++;
                end
            end
        end
    end

    // One APB transfer; the reference model predicts the completion and AXI requests.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input int unsigned lat);
        apb_exp_t    e;
        logic [31:0] a;
        int          n;
        a = addr & 32'hFFFF_FFFC;
        @(negedge clk);
        e.t0  = cyc;
        e.lat = lat;
        if (wr) begin
            e.data = 32'h0;
            e.err  = (cfg_bresp != 2'b00) || (cfg_bid != TB_ID);
            m_mem[a] = data;
            exp_aw.push_back(a);
            exp_w.push_back(data);
        end else begin
            e.data = ovr_en ? ovr_data : (m_mem.exists(a) ? m_mem[a] : def_word(a));
            e.err  = (cfg_rresp != 2'b00) || (cfg_rid != TB_ID) || !cfg_rlast;
            exp_ar.push_back(a);
        end
        sb_q.push_back(e);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
        @(negedge clk);
        penable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pready_o && n < 200);
        if (!pready_o) check("pready timeout", 0, 1);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic cfg_ok();
        {aw_delay, w_delay, b_delay, ar_delay, r_delay} = '0;
        cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_bid = TB_ID; cfg_rid = TB_ID;
        cfg_rlast = 1'b1; ovr_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish by 500us");
        $fatal(1);
    end

    initial begin
        int unsigned md, kind, n;
        logic        wr;
        logic [31:0] addr;
        rst = 1'b1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        repeat (3) @(negedge clk);
        check("rst ctrl", {awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, pready_o,
                           pslverr_o}, 7'd0);
        check("rst prdata", prdata_o, 0);
        check("rst addr", {awaddr_o, araddr_o}, 0);
        check("rst wdata", wdata_o, 0);
        rst = 1'b0;
        cfg_ok();

        apb_xfer(1'b1, 32'h0001_F010, 32'hDEAD_BEEF, 3);
        apb_xfer(1'b0, 32'h0001_F010, 32'h0, 3);

        aw_delay = 3;
        {aw_hi_cnt, w_hi_cnt, b_hs_cnt} = '0;
        apb_xfer(1'b1, 32'h0001_F020, 32'hCAFE_F00D, 6);
        check("skew awvalid cycles", aw_hi_cnt, 4);
        check("skew wvalid cycles", w_hi_cnt, 1);
        check("skew b count", b_hs_cnt, 1);
        cfg_ok();

        cfg_rresp = 2'b10; ovr_en = 1'b1; ovr_data = 32'h1234_5678;
        apb_xfer(1'b0, 32'h0001_F010, 32'h0, 3);
        cfg_ok();
        cfg_bresp = 2'b11;
        apb_xfer(1'b1, 32'h0000_0100, 32'h0000_0001, 3);
        cfg_ok();
        apb_xfer(1'b1, 32'h0002_F013, 32'hA5A5_0F0F, 3);
        cfg_rlast = 1'b0;
        apb_xfer(1'b0, 32'h0002_F010, 32'h0, 3);
        cfg_ok();
        cfg_bid = 4'h0;
        apb_xfer(1'b1, 32'h0002_F014, 32'h0BAD_1D00, 3);
        cfg_ok();

        // Reset while waiting for B
        b_delay = 50;
        @(negedge clk);
        exp_aw.push_back(32'h0004_0000);
        exp_w.push_back(32'h7777_7777);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0004_0000; pwdata = 32'h7777_7777;
        @(negedge clk);
        penable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bready_o && n < 30);
        check("wr_resp reached", bready_o, 1);
        rst = 1'b1;
        #1;
        check("async rst ctrl", {awvalid_o, wvalid_o, arvalid_o, bready_o, rready_o, pready_o},
              6'd0);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cfg_ok();
        apb_xfer(1'b0, 32'h0001_F010, 32'h0, 3);

        for (int i = 0; i < 60; i++) begin
            wr   = 1'($urandom_range(0, 1));
            addr = 32'h0003_0000 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            aw_delay = $urandom_range(0, 3);
            w_delay  = $urandom_range(0, 3);
            b_delay  = $urandom_range(0, 3);
            ar_delay = $urandom_range(0, 3);
            r_delay  = $urandom_range(0, 3);
            kind = $urandom_range(0, 9);
            cfg_bresp = (kind == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cfg_rresp = (kind == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cfg_bid   = (kind == 1) ? (TB_ID ^ 4'h3) : TB_ID;
            cfg_rid   = (kind == 1) ? (TB_ID ^ 4'h3) : TB_ID;
            cfg_rlast = (kind == 2) ? 1'b0 : 1'b1;
            md = (aw_delay > w_delay) ? aw_delay : w_delay;
            apb_xfer(wr, addr, $urandom, wr ? (3 + md + b_delay) : (3 + ar_delay + r_delay));
        end

        repeat (3) @(negedge clk);
        check("sb leftover", sb_q.size(), 0);
        check("aw leftover", exp_aw.size(), 0);
        check("w leftover", exp_w.size(), 0);
        check("ar leftover", exp_ar.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
